// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
// Revision 1.0
`default_nettype none

package fetch_pkg;

  localparam int FETCH_ADDR_W    = 16;
  localparam int FETCH_INSTR_W   = 16;
  localparam int FETCH_MEM_DEPTH = 64;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1110;

  localparam logic [FETCH_INSTR_W-1:0] FLUSH_INSTR = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush beats load, load beats kill.
// Revision 1.0
`default_nettype none

module if_id_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               kill_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc1_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc1_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc1_q;
  logic               valid_q;

  // kill only drops the valid flag so the stale word never reaches decode as real
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc1_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= INSTR_W'(FLUSH_INSTR);
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc1_q   <= pc1_i;
      valid_q <= 1'b1;
    end else if (kill_i) begin
      valid_q <= 1'b0;
    end
  end

  assign instr_o = instr_q;
  assign pc1_o   = pc1_q;
  assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: PC, fetch FSM and IF/ID capture for an async-read instruction memory.
// Revision 1.0
`default_nettype none

module if_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = FETCH_ADDR_W,
  parameter int INSTR_W   = FETCH_INSTR_W,
  parameter int MEM_DEPTH = FETCH_MEM_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt_req,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc1,
  output logic               if_id_valid,
  output logic               halted,
  output logic [15:0]        fetch_cnt
);

  localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [15:0]       CNT_MAX = 16'hFFFF;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [15:0]       cnt_q, cnt_d;
  logic              halted_q;

  logic branch_go, stall_go, halt_go, fetch_go;

  // STALL with stall released behaves exactly like RUN, so the held PC is fetched at once
  always_comb begin
    branch_go = 1'b0;
    stall_go  = 1'b0;
    halt_go   = 1'b0;
    fetch_go  = 1'b0;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (branch_taken)  branch_go = 1'b1;
        else if (stall)    stall_go  = 1'b1;
        else if (halt_req) halt_go   = 1'b1;
        else               fetch_go  = 1'b1;
      end
      ST_HALT: branch_go = branch_taken;
      default: ;
    endcase
  end

  assign pc_inc = (pc_q + ADDR_W'(1)) & PC_MASK;

  always_comb begin
    pc_d = pc_q;
    if (branch_go)     pc_d = branch_target & PC_MASK;
    else if (fetch_go) pc_d = pc_inc;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (fetch_go && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 16'd1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN, ST_STALL: begin
        if (branch_go)     state_d = ST_RUN;
        else if (stall_go) state_d = ST_STALL;
        else if (halt_go)  state_d = ST_HALT;
        else               state_d = ST_RUN;
      end
      ST_HALT: if (branch_go) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      pc_q     <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == ST_HALT);
    end
  end

  if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (fetch_go),
    .flush_i (branch_go),
    .kill_i  (halt_go),
    .instr_i (instr_in),
    .pc1_i   (pc_inc),
    .instr_o (if_id_instr),
    .pc1_o   (if_id_pc1),
    .valid_o (if_id_valid)
  );

  assign instr_addr = pc_q;
  assign halted     = halted_q;
  assign fetch_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed and randomized checks of if_fetch_ctrl against a behavioural model.
// Revision 1.0
`default_nettype none

module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr_addr;
  logic [15:0] instr_in;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halt_req;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc1;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_cnt;

  logic [15:0] mem [64];

  int checks;
  int failures;

  // Behavioural model of what decode should observe
  bit          m_boot;
  bit          m_halted;
  int          m_pc;
  logic [15:0] m_instr;
  int          m_pc1;
  bit          m_valid;
  int          m_cnt;

  if_fetch_ctrl #(
    .ADDR_W    (16),
    .INSTR_W   (16),
    .MEM_DEPTH (64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_addr    (instr_addr),
    .instr_in      (instr_in),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .if_id_instr   (if_id_instr),
    .if_id_pc1     (if_id_pc1),
    .if_id_valid   (if_id_valid),
    .halted        (halted),
    .fetch_cnt     (fetch_cnt)
  );

  assign instr_in = mem[instr_addr[5:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_boot   = 1'b1;
    m_halted = 1'b0;
    m_pc     = 0;
    m_instr  = 16'h0000;
    m_pc1    = 0;
    m_valid  = 1'b0;
    m_cnt    = 0;
  endtask

  task automatic m_step(input bit br, input logic [15:0] tgt, input bit st, input bit hr);
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (br) begin
      m_pc     = tgt % 64;
      m_valid  = 1'b0;
      m_instr  = 16'h0000;
      m_halted = 1'b0;
    end else if (m_halted || st) begin
      // nothing moves
    end else if (hr) begin
      m_valid  = 1'b0;
      m_halted = 1'b1;
    end else begin
      m_instr = mem[m_pc];
      m_pc    = (m_pc + 1) % 64;
      m_pc1   = m_pc;
      m_valid = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic check_all();
    chk("instr_addr", instr_addr, m_pc);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_pc1", if_id_pc1, m_pc1);
    chk("if_id_valid", if_id_valid, m_valid);
    chk("halted", halted, m_halted);
    chk("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  task automatic cyc(input bit br, input logic [15:0] tgt, input bit st, input bit hr);
    branch_taken  = br;
    branch_target = tgt;
    stall         = st;
    halt_req      = hr;
    @(posedge clk);
    m_step(br, tgt, st, hr);
    #1;
    check_all();
  endtask

  // Reset asserted and released away from clock edges
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    rst_n         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    halt_req      = 1'b0;
    m_reset();
    #12;
    check_all();
    #5;
    rst_n = 1'b1;

    // boot bubble ignores every event, then sequential fetch
    cyc(1'b1, 16'd7, 1'b1, 1'b1);
    chk("boot_valid", if_id_valid, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'd0, 1'b0, 1'b0);
    chk("seq_pc1", if_id_pc1, 16'd4);
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'd0, 1'b1, 1'b0);
    chk("stall_addr", instr_addr, 16'd4);
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    chk("unstall_instr", if_id_instr, mem[4]);
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    // branch beats stall
    cyc(1'b1, 16'd9, 1'b1, 1'b0);
    chk("br_addr", instr_addr, 16'd9);
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    chk("br_instr", if_id_instr, mem[9]);
    // halt is absorbing until a branch
    cyc(1'b1, 16'd3, 1'b0, 1'b0);
    cyc(1'b0, 16'd0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 16'd0, 1'(i % 2), 1'(i % 3 == 0));
    chk("halt_hold", halted, 1'b1);
    cyc(1'b1, 16'd2, 1'b0, 1'b0);
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    chk("halt_exit_instr", if_id_instr, mem[2]);
    // wrap and target masking
    cyc(1'b1, 16'd63, 1'b0, 1'b0);
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    chk("wrap_addr", instr_addr, 16'd0);
    chk("wrap_pc1", if_id_pc1, 16'd0);
    cyc(1'b1, 16'h0045, 1'b0, 1'b0);
    chk("mask_addr", instr_addr, 16'd5);
    // reset while halted, then while stalled
    cyc(1'b0, 16'd0, 1'b0, 1'b1);
    do_reset();
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    cyc(1'b0, 16'd0, 1'b1, 1'b0);
    do_reset();

    // randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cyc($urandom_range(0, 99) < 10, 16'($urandom), $urandom_range(0, 99) < 25,
          $urandom_range(0, 99) < 8);
    end

    // fetch counter saturation
    do_reset();
    for (int i = 0; i < 65540; i++) cyc(1'b0, 16'd0, 1'b0, 1'b0);
    chk("cnt_sat", fetch_cnt, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
